// File: rtl/stopwatch_core_pkg.sv
// Shared types and constants for the stopwatch core: FSM states, BCD digit limits, display width.
package stopwatch_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_e;

    localparam int DIGITS_W   = 16;
    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 4;

    localparam logic [DIG_W-1:0] MAX_UNITS = 4'd9;
    localparam logic [DIG_W-1:0] MAX_TENS  = 4'd5;

    // Digit order, LSD first: tenths, sec_units, sec_tens, min. Only sec_tens stops at 5.
    function automatic logic [DIG_W-1:0] digit_max(input int idx);
        return (idx == 2) ? MAX_TENS : MAX_UNITS;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Stopwatch I/O bundle: update wave and buttons in, BCD digits and status out.
interface stopwatch_core_if;
    import stopwatch_core_pkg::*;

    logic                clk_update;
    logic                btn_start;
    logic                btn_lap;
    logic                btn_clear;
    logic [DIGITS_W-1:0] digits;
    logic                running;
    logic                lap_active;
    logic                overflow;

    modport master (
        output clk_update, btn_start, btn_lap, btn_clear,
        input  digits, running, lap_active, overflow
    );

    modport slave (
        input  clk_update, btn_start, btn_lap, btn_clear,
        output digits, running, lap_active, overflow
    );

endinterface

// File: rtl/stopwatch_core_bcd_digit_cnt.sv
// One BCD digit, counts 0..MAX; carry_out is combinational so a whole chain ripples in one cycle.
module bcd_digit_cnt
    import stopwatch_core_pkg::*;
#(
    parameter logic [DIG_W-1:0] MAX = 4'd9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_in,
    input  logic             clr,
    output logic [DIG_W-1:0] q,
    output logic             carry_out
);

    assign carry_out = inc_in && (q == MAX);

    always_ff @(posedge clk) begin
        if (!rst || clr)
            q <= '0;
        else if (inc_in)
            q <= carry_out ? '0 : q + DIG_W'(1);
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch M:SS.t in BCD: samples the divider update wave as data, prescales it to 0.1 s,
// and runs the start/lap/clear state machine with a frozen lap view.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int TICKS_PER_COUNT = 2,
    parameter int PRE_W           = 4
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_core_if.slave bus
);

    sw_state_e                         state, state_nxt;
    logic [1:0]                        upd_sync;
    logic                              upd_prev, tick;
    logic                              start_prev, lap_prev, clear_prev;
    logic                              press_start, press_lap, press_clear;
    logic [PRE_W-1:0]                  pre;
    logic                              pre_wrap, count_en, inc, capture, clr_cnt;
    logic [NUM_DIGITS-1:0][DIG_W-1:0]  cnt;
    logic [NUM_DIGITS:0]               carry;
    logic [DIGITS_W-1:0]               lap_q, digits_q;
    logic                              ovf_q;

    assign press_start = bus.btn_start & ~start_prev;
    assign press_lap   = bus.btn_lap   & ~lap_prev;
    assign press_clear = bus.btn_clear & ~clear_prev;

    // Priority start > lap > clear falls out of the if/else ordering in each state.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            IDLE:  if (press_start) state_nxt = RUN;
            RUN:   if (press_start) state_nxt = PAUSE;
                   else if (press_lap) begin
                       state_nxt = LAP;
                       capture   = 1'b1;
                   end
            LAP:   if (press_start) state_nxt = PAUSE;
                   else if (press_lap) state_nxt = RUN;
            PAUSE: if (press_start) state_nxt = RUN;
                   else if (press_clear) begin
                       state_nxt = IDLE;
                       clr_cnt   = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    // Gating on the next state drops a tick that coincides with a pause press
    // and keeps one that coincides with a resume press.
    assign count_en = (state_nxt == RUN) || (state_nxt == LAP);
    assign pre_wrap = (pre == PRE_W'(TICKS_PER_COUNT - 1));
    assign inc      = tick && count_en && pre_wrap;
    assign carry[0] = inc;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        bcd_digit_cnt #(.MAX(digit_max(i))) u_dig (
            .clk       (clk),
            .rst       (rst),
            .inc_in    (carry[i]),
            .clr       (clr_cnt),
            .q         (cnt[i]),
            .carry_out (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            upd_sync   <= '0;
            upd_prev   <= 1'b0;
            tick       <= 1'b0;
            start_prev <= 1'b0;
            lap_prev   <= 1'b0;
            clear_prev <= 1'b0;
            pre        <= '0;
            lap_q      <= '0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            upd_sync   <= {upd_sync[0], bus.clk_update};
            upd_prev   <= upd_sync[1];
            tick       <= upd_sync[1] & ~upd_prev;
            start_prev <= bus.btn_start;
            lap_prev   <= bus.btn_lap;
            clear_prev <= bus.btn_clear;
            if (clr_cnt)
                pre <= '0;
            else if (tick && count_en)
                pre <= pre_wrap ? '0 : pre + PRE_W'(1);
            if (capture)
                lap_q <= cnt;
            digits_q   <= (state == LAP) ? lap_q : cnt;
            ovf_q      <= carry[NUM_DIGITS];
        end
    end

    assign bus.digits     = digits_q;
    assign bus.overflow   = ovf_q;
    assign bus.running    = (state == RUN) || (state == LAP);
    assign bus.lap_active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a tenths-of-a-second model feeds an expected-digits queue.
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stopwatch_core_if bus ();

    stopwatch_core #(.TICKS_PER_COUNT(2), .PRE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int ovf_cnt  = 0;

    // Model: m = count in tenths, pre = prescaler, lap_m = frozen lap value.
    int m = 0, pre = 0, lap_m = 0;
    bit run = 1'b0, lapmode = 1'b0;
    logic [15:0] sb_q[$];

    always @(negedge clk) if (bus.overflow === 1'b1) ovf_cnt++;

    function automatic logic [15:0] to_bcd(input int t);
        int s;
        s = (t / 10) % 60;
        return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rises(input int n, input int hp);
        for (int k = 0; k < n; k++) begin
            bus.clk_update = 1'b1;
            cyc(hp);
            bus.clk_update = 1'b0;
            cyc(hp);
            if (run) begin
                pre++;
                if (pre == 2) begin
                    pre = 0;
                    m   = (m + 1) % 6000;
                end
            end
        end
    endtask

    task automatic press(input bit s, input bit l, input bit c);
        bus.btn_start = s;
        bus.btn_lap   = l;
        bus.btn_clear = c;
        cyc(1);
        bus.btn_start = 1'b0;
        bus.btn_lap   = 1'b0;
        bus.btn_clear = 1'b0;
        cyc(1);
    endtask

    task automatic expect_disp();
        sb_q.push_back(to_bcd(lapmode ? lap_m : m));
    endtask

    task automatic check_disp(input string tag);
        logic [15:0] e;
        cyc(2);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s: observed empty queue expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk16(tag, bus.digits, e);
        end
    endtask

    initial begin
        rst            = 1'b0;
        bus.clk_update = 1'b0;
        bus.btn_start  = 1'b0;
        bus.btn_lap    = 1'b0;
        bus.btn_clear  = 1'b0;

        // Reset held with inputs toggling
        for (int k = 0; k < 3; k++) begin
            bus.clk_update = 1'(k);
            bus.btn_start  = 1'($urandom_range(0, 1));
            bus.btn_lap    = 1'($urandom_range(0, 1));
            bus.btn_clear  = 1'($urandom_range(0, 1));
            cyc(1);
            chk16("rst_digits", bus.digits, 16'h0000);
            chk1("rst_running", bus.running, 1'b0);
            chk1("rst_overflow", bus.overflow, 1'b0);
            chk1("rst_lap", bus.lap_active, 1'b0);
        end
        bus.clk_update = 1'b0;
        bus.btn_start  = 1'b0;
        bus.btn_lap    = 1'b0;
        bus.btn_clear  = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(3);
        chk1("idle_running", bus.running, 1'b0);

        // Start, one second, then pause holds
        press(1, 0, 0); run = 1;
        chk1("start_running", bus.running, 1'b1);
        rises(20, 5); expect_disp(); check_disp("run_1s");
        press(1, 0, 0); run = 0;
        chk1("pause_running", bus.running, 1'b0);
        rises(40, 5); expect_disp(); check_disp("pause_hold");
        press(0, 0, 1); m = 0; pre = 0;
        expect_disp(); check_disp("clear_from_pause");
        chk1("clear_idle", bus.running, 1'b0);

        // Full range and wrap, with a faster update wave
        press(1, 0, 0); run = 1;
        rises(11998, 2); expect_disp(); check_disp("max_959");
        chk16("no_ovf_before_wrap", 16'(ovf_cnt), 16'd0);
        rises(2, 2); expect_disp(); check_disp("wrap_zero");
        chk16("ovf_once", 16'(ovf_cnt), 16'd1);
        rises(2, 2); expect_disp(); check_disp("after_wrap");

        // Lap freeze while counting continues
        press(1, 0, 0); run = 0;
        press(0, 0, 1); m = 0; pre = 0;
        press(1, 0, 0); run = 1;
        rises(46, 5); expect_disp(); check_disp("run_023");
        press(0, 1, 0); lap_m = m; lapmode = 1;
        chk1("lap_active", bus.lap_active, 1'b1);
        expect_disp(); check_disp("lap_hold");
        rises(16, 5); expect_disp(); check_disp("lap_frozen");
        chk1("lap_running", bus.running, 1'b1);
        press(0, 1, 0); lapmode = 0;
        chk1("lap_resume_flag", bus.lap_active, 1'b0);
        expect_disp(); check_disp("lap_resume_live");
        press(0, 1, 0); lap_m = m; lapmode = 1;
        expect_disp(); check_disp("lap_031");
        press(0, 1, 0); lapmode = 0;

        // Clear ignored in RUN; clear from PAUSE; simultaneous buttons
        press(0, 0, 1);
        chk1("clear_in_run", bus.running, 1'b1);
        expect_disp(); check_disp("clear_in_run_digits");
        rises(2, 5); expect_disp(); check_disp("run_after_clear");
        press(1, 0, 0); run = 0;
        press(0, 0, 1); m = 0; pre = 0;
        expect_disp(); check_disp("clear_zero");
        chk1("clear_to_idle", bus.running, 1'b0);
        press(1, 0, 0); run = 1;
        rises(6, 5);
        press(1, 0, 0); run = 0;
        press(1, 1, 1); run = 1;
        chk1("combo_running", bus.running, 1'b1);
        chk1("combo_no_lap", bus.lap_active, 1'b0);
        expect_disp(); check_disp("combo_no_clear");
        rises(2, 5); expect_disp(); check_disp("combo_counts");

        // Reset mid-run with a half-filled prescaler
        rises(106, 5); expect_disp(); check_disp("run_057");
        rises(1, 5);
        rst = 1'b0;
        cyc(1);
        chk16("midrst_digits", bus.digits, 16'h0000);
        chk1("midrst_running", bus.running, 1'b0);
        chk1("midrst_lap", bus.lap_active, 1'b0);
        chk1("midrst_ovf", bus.overflow, 1'b0);
        rst = 1'b1; m = 0; pre = 0; run = 0; lapmode = 0;
        cyc(2);
        chk1("post_rst_idle", bus.running, 1'b0);
        press(1, 0, 0); run = 1;
        rises(1, 5); expect_disp(); check_disp("prescaler_cleared");

        // Update rise before edge E: count moves at E+3, registered digits at E+4
        bus.clk_update = 1'b1;
        cyc(4);
        chk16("latency_e3", bus.digits, 16'h0000);
        cyc(1);
        chk16("latency_e4", bus.digits, 16'h0001);
        bus.clk_update = 1'b0;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
